// File: rtl/ah_arb_pkg.sv
// Shared definitions for the LRU arbiter and its grant-consumer stage.
package ah_arb_pkg;

  localparam int AH_NUM_REQ = 10;
  localparam int AH_ID_W    = 4;
  localparam int AH_LEN_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } ah_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [AH_ID_W-1:0] ah_onehot2idx(input logic [AH_NUM_REQ-1:0] v);
    logic [AH_ID_W-1:0] idx;
    idx = '0;
    for (int i = AH_NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = AH_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ah_onehot_enc.sv
// Lowest-set-bit priority encoder with a multi-hot indicator.
module ah_onehot_enc
  import ah_arb_pkg::*;
#(
  parameter int NUM_REQ = AH_NUM_REQ,
  parameter int ID_W    = AH_ID_W
) (
  input  logic [NUM_REQ-1:0] vec_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               multi_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign multi_o = |(vec_i & (vec_i - NUM_REQ'(1)));

endmodule

// File: rtl/ah_gnt_burst_ctrl.sv
// Grant consumer: latches the arbiter's winner and streams its burst downstream.
module ah_gnt_burst_ctrl
  import ah_arb_pkg::*;
#(
  parameter int NUM_REQ = AH_NUM_REQ,
  parameter int ID_W    = AH_ID_W,
  parameter int LEN_W   = AH_LEN_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt_busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err_multi,
  output logic                     err_ovr
);

  ah_state_e            state_q;
  logic [LEN_W-1:0]     remain_q;
  logic [ID_W-1:0]      out_id_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_multi_q;
  logic                 err_ovr_q;

  logic [ID_W-1:0]      enc_idx;
  logic                 enc_multi;
  logic [LEN_W-1:0]     len_sel;

  ah_onehot_enc #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_enc (
    .vec_i   (gnt),
    .idx_o   (enc_idx),
    .multi_o (enc_multi)
  );

  // Pick the burst length belonging to the encoded winner.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enc_idx == ID_W'(i)) len_sel = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Burst FSM with registered beat outputs, completion pulse and sticky errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= '0;
      err_multi_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            out_id_q    <= enc_idx;
            remain_q    <= len_sel;
            out_last_q  <= (len_sel == '0);
            out_valid_q <= 1'b1;
            state_q     <= ST_XFER;
            if (enc_multi) err_multi_q <= 1'b1;
          end
        end
        ST_XFER: begin
          if (|gnt) err_ovr_q <= 1'b1;
          if (out_ready) begin
            if (remain_q != '0) begin
              remain_q   <= remain_q - LEN_W'(1);
              out_last_q <= (remain_q == LEN_W'(1));
            end else begin
              // Final beat taken: completion pulse covers the single GAP cycle.
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= NUM_REQ'(1) << out_id_q;
              state_q     <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (|gnt) err_ovr_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Arbiter is held off for the whole burst plus the GAP cycle.
  assign gnt_busy  = {NUM_REQ{state_q != ST_IDLE}};
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign done      = done_q;
  assign err_multi = err_multi_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_ah_gnt_burst_ctrl.sv
// Self-checking bench for ah_gnt_burst_ctrl against a beat-counting reference model.
module tb_ah_gnt_burst_ctrl;

  localparam int NR = 10;
  localparam int IW = 4;
  localparam int LW = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NR-1:0]        gnt;
  logic [NR*LW-1:0]     req_len;
  logic [NR-1:0]        gnt_busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_id;
  logic                 out_last;
  logic [NR-1:0]        done;
  logic                 err_multi;
  logic                 err_ovr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: beats still owed, one gap cycle, expected completion pulse.
  int            m_beats;
  bit            m_gap;
  int            m_id;
  logic [NR-1:0] m_done;
  bit            m_multi;
  bit            m_ovr;

  ah_gnt_burst_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .gnt       (gnt),
    .req_len   (req_len),
    .gnt_busy  (gnt_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_last  (out_last),
    .done      (done),
    .err_multi (err_multi),
    .err_ovr   (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  function automatic int lowest_bit(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_beats = 0;
    m_gap   = 0;
    m_id    = 0;
    m_done  = '0;
    m_multi = 0;
    m_ovr   = 0;
  endtask

  // Advance the model by one rising edge given the inputs present at that edge.
  task automatic model_edge(input logic [NR-1:0] g, input logic rdy);
    logic [NR-1:0] nd;
    nd = '0;
    if (m_beats > 0) begin
      if (g != 0) m_ovr = 1;
      if (rdy) begin
        if (m_beats == 1) begin
          m_beats = 0;
          m_gap   = 1;
          nd[m_id] = 1'b1;
        end else begin
          m_beats--;
        end
      end
    end else if (m_gap) begin
      if (g != 0) m_ovr = 1;
      m_gap = 0;
    end else if (g != 0) begin
      m_id    = lowest_bit(g);
      m_beats = int'(req_len[m_id*LW +: LW]) + 1;
      if ($countones(g) > 1) m_multi = 1;
    end
    m_done = nd;
  endtask

  task automatic check_outputs();
    bit busy_exp;
    busy_exp = (m_beats > 0) || m_gap;
    chk("out_valid", out_valid, m_beats > 0);
    chk("gnt_busy", gnt_busy, busy_exp ? {NR{1'b1}} : '0);
    chk("done", done, m_done);
    chk("err_multi", err_multi, m_multi);
    chk("err_ovr", err_ovr, m_ovr);
    if (m_beats > 0) begin
      chk("out_id", out_id, m_id);
      chk("out_last", out_last, m_beats == 1);
    end
  endtask

  task automatic step(input logic [NR-1:0] g, input logic rdy);
    gnt       = g;
    out_ready = rdy;
    @(posedge clk);
    model_edge(g, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1);
  endtask

  task automatic check_reset_values();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", gnt_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", out_id, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err_multi", err_multi, 0);
    chk("rst_err_ovr", err_ovr, 0);
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [4:0]    rdy_pat;
    int            accepts;

    rstn      = 1'b0;
    gnt       = '0;
    out_ready = 1'b0;
    req_len   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rstn = 1'b1;
    idle_steps(2);

    // Four-beat burst for requester 2.
    set_len(2, 3);
    step(10'b0000000100, 1'b1);
    idle_steps(7);

    // Single-beat burst for requester 9.
    set_len(9, 0);
    step(10'b1000000000, 1'b1);
    idle_steps(4);

    // Three-beat burst under backpressure; count the accepts as they happen.
    set_len(5, 2);
    step(10'b0000100000, 1'b0);
    rdy_pat = 5'b11001;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid && rdy_pat[i]) accepts++;
      step('0, rdy_pat[i]);
    end
    chk("bp_accepts", accepts, 3);
    idle_steps(3);

    // Multi-hot grant: lowest bit wins, sticky error raised.
    set_len(3, 1);
    step(10'b0000101000, 1'b1);
    idle_steps(5);

    // Grant arriving during a burst is ignored but flagged.
    set_len(4, 3);
    step(10'b0000010000, 1'b1);
    step(10'b0000000001, 1'b1);
    idle_steps(6);

    // Reset in the middle of a five-beat burst.
    set_len(6, 4);
    step(10'b0001000000, 1'b1);
    step('0, 1'b1);
    rstn = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rstn = 1'b1;
    idle_steps(2);
    set_len(1, 2);
    step(10'b0000000010, 1'b1);
    idle_steps(6);

    // Randomized traffic: random lengths, grants (including multi-hot and overruns), ready.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, NR - 1), $urandom_range(0, 15));
      g = '0;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) g = NR'($urandom_range(1, 1023));
        else g[$urandom_range(0, NR - 1)] = 1'b1;
      end
      step(g, $urandom_range(0, 3) != 0);
    end
    idle_steps(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
